dbg_mem_arb: RTL

Two-port memory arbiter sharing the single synchronous on-chip RAM between the b16 core data port and the UART debug port. Each requester sees a simple hold-until-ack request interface. The arbiter serialises accesses, drives the RAM strobes, and returns a one-cycle acknowledge together with read data. It sits between the core/debug UART and the RAM macro, and also produces the status byte consumed by the debug UART.

---
 rtl/dbg_mem_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dbg_mem_arb.sv
`timescale 1ns/1ps
// Two-port (core/debug) arbiter onto one synchronous RAM; tie policy set by DBG_MEM_ARB_RR_EN.
// Latency: request sampled at edge N -> mem_cs in cycle N+1 -> ack in cycle N+2; one access per 3 cycles.
// Backpressure: requesters hold cs until their one-cycle ack; a losing requester simply waits in IDLE.
module dbg_mem_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r,
    input  logic [1:0]  cpu_wr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_cs,
    input  logic [15:0] dbg_addr,
    input  logic        dbg_r,
    input  logic [1:0]  dbg_wr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic [7:0]  status,
    output logic        mem_cs,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2} state_t;

    state_t      state, state_n;
    logic        req_any, pick_dbg, gnt_n;
    logic        gnt_dbg, is_read, last_dbg, dbg_ack;
    logic [15:0] cpu_rdata_q, dbg_rdata_q;
    logic [7:0]  status_q, status_n;
    logic        unused_addr_lsb;

    // Byte-address bit 0 has no meaning for a word RAM; byte steering is the requester's job.
    assign unused_addr_lsb = cpu_addr[0] ^ dbg_addr[0];

    // Pick the winner for the next grant; a lone requester always wins.
    always_comb begin
        req_any = cpu_cs | dbg_cs;
`ifdef DBG_MEM_ARB_RR_EN
        pick_dbg = dbg_cs & (~cpu_cs | ~last_dbg);
`else
        pick_dbg = dbg_cs;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next state: IDLE only samples requests, so the cycle after ACK is a fresh arbitration.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_any) state_n = ISSUE;
            ISSUE:   state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign cpu_ack = (state == ACK) & ~gnt_dbg;
    assign dbg_ack = (state == ACK) & gnt_dbg;

    // RAM read data lands in the ACK cycle, so it is forwarded there and held in a register afterwards.
    assign cpu_rdata = (cpu_ack & is_read) ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata = (dbg_ack & is_read) ? mem_rdata : dbg_rdata_q;
    assign status    = status_q;

    // Access registers: latch the winner on grant, drop the strobe after one cycle, capture read data on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_dbg     <= 1'b0;
            is_read     <= 1'b0;
            last_dbg    <= 1'b0;
            mem_cs      <= 1'b0;
            mem_addr    <= 15'd0;
            mem_we      <= 2'b00;
            mem_wdata   <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dbg_rdata_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_dbg   <= pick_dbg;
                        mem_cs    <= 1'b1;
                        mem_addr  <= pick_dbg ? dbg_addr[15:1] : cpu_addr[15:1];
                        mem_we    <= pick_dbg ? dbg_wr : cpu_wr;
                        mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                        is_read   <= pick_dbg ? (dbg_r & (dbg_wr == 2'b00))
                                              : (cpu_r & (cpu_wr == 2'b00));
                    end
                end
                ISSUE: begin
                    mem_cs <= 1'b0;
                    mem_we <= 2'b00;
                end
                ACK: begin
                    // last_dbg records the most recently completed grant.
                    last_dbg <= gnt_dbg;
                    if (is_read) begin
                        if (gnt_dbg) dbg_rdata_q <= mem_rdata;
                        else         cpu_rdata_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status computed from next-cycle values so the registered byte lines up with the state it describes.
    always_comb begin
        gnt_n       = (state == IDLE) ? pick_dbg : gnt_dbg;
        status_n    = 8'h00;
        status_n[0] = (state_n != IDLE);
        status_n[1] = (state_n == ACK) & gnt_n;
        status_n[2] = (state == ACK) ? gnt_dbg : last_dbg;
        status_n[3] = cpu_cs & ~cpu_ack & ~((state_n != IDLE) & ~gnt_n);
    end

    // Status register.
    always_ff @(posedge clk) begin
        if (reset) status_q <= 8'h00;
        else       status_q <= status_n;
    end

endmodule
